// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller with saturating event counters
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rs,
  input  logic             ifid_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             br_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] hold_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    HOLD_BR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;

  logic lu_det;
  logic ev_hold;
  logic ev_flush;
  logic ev_lu;

  // Load in EX whose destination feeds an operand read in ID; r0 never creates a dependency.
  assign lu_det = idex_mem_read && (idex_rt != 5'd0) &&
                  ((ifid_uses_rs && (ifid_rs == idex_rt)) ||
                   (ifid_uses_rt && (ifid_rt == idex_rt)));

  // Event priority: memory hold beats branch flush beats load-use bubble.
  // A branch parked in HOLD_BR flushes on the first non-busy cycle.
  assign ev_hold  = dmem_busy;
  assign ev_flush = !dmem_busy && (br_taken || (state == HOLD_BR));
  assign ev_lu    = !dmem_busy && !ev_flush && lu_det;

  // State register; reset drops any pending branch flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state: track whether a hold is active and whether a taken branch is waiting behind it.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (dmem_busy) state_nxt = br_taken ? HOLD_BR : HOLD;
      end
      HOLD: begin
        if (!dmem_busy)    state_nxt = RUN;
        else if (br_taken) state_nxt = HOLD_BR;
      end
      HOLD_BR: begin
        if (!dmem_busy) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Output decode: reset forces every pipeline register to load a bubble, otherwise map the winning event.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_flush  = 1'b0;
    pipe_hold    = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (ev_hold) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      pipe_hold    = 1'b1;
      memwb_bubble = 1'b1;
    end else if (ev_flush) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_flush  = 1'b1;
    end else if (ev_lu) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_bubble  = 1'b1;
    end
  end

  // Saturating event counters, one increment per cycle in which the event wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt    <= '0;
      hold_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (ev_lu && (lu_cnt != CNT_MAX))       lu_cnt    <= lu_cnt + CNT_ONE;
      if (ev_hold && (hold_cnt != CNT_MAX))   hold_cnt  <= hold_cnt + CNT_ONE;
      if (ev_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt;
  logic        ifid_uses_rs, ifid_uses_rt, idex_mem_read, br_taken, dmem_busy;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, memwb_bubble;
  logic [15:0] lu_cnt, hold_cnt, flush_cnt;
  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_exmem_flush, s_pipe_hold, s_memwb_bubble;
  logic [1:0]  s_lu_cnt, s_hold_cnt, s_flush_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected control vectors: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, memwb_bubble}
  localparam logic [6:0] C_IDLE  = 7'b1100000;
  localparam logic [6:0] C_HOLD  = 7'b0000011;
  localparam logic [6:0] C_FLUSH = 7'b1111100;
  localparam logic [6:0] C_LU    = 7'b0001000;
  localparam logic [6:0] C_RST   = 7'b0011101;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .br_taken(br_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_flush(exmem_flush), .pipe_hold(pipe_hold), .memwb_bubble(memwb_bubble),
    .lu_cnt(lu_cnt), .hold_cnt(hold_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .br_taken(br_taken), .dmem_busy(dmem_busy),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
    .exmem_flush(s_exmem_flush), .pipe_hold(s_pipe_hold), .memwb_bubble(s_memwb_bubble),
    .lu_cnt(s_lu_cnt), .hold_cnt(s_hold_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, memwb_bubble},
        {25'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input int elu, input int ehold, input int eflush);
    chk({tag, "_lu"},    {16'd0, lu_cnt},    elu);
    chk({tag, "_hold"},  {16'd0, hold_cnt},  ehold);
    chk({tag, "_flush"}, {16'd0, flush_cnt}, eflush);
  endtask

  task automatic idle_in();
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rs = 1'b0; ifid_uses_rt = 1'b0;
    idex_mem_read = 1'b0; idex_rt = 5'd0; br_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic set_lu();
    idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_uses_rs = 1'b1;
  endtask

  // Advance one clock; inputs may then change and outputs settle #1 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    dmem_busy = 1'b1;
    br_taken = 1'b1;
    #2;
    chk_ctl("reset_outputs", C_RST);
    chk_cnt("reset", 0, 0, 0);
    cyc(); cyc();
    rst = 1'b0;
    idle_in();
    #1;
    chk_ctl("idle_after_reset", C_IDLE);

    // Load-use via rs: one bubble, then clears.
    set_lu();
    #1; chk_ctl("lu_rs", C_LU);
    cyc();
    idle_in();
    #1; chk_ctl("lu_gone", C_IDLE);
    chk_cnt("lu1", 1, 0, 0);

    // Destination r0 never stalls.
    idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_uses_rs = 1'b1;
    #1; chk_ctl("lu_r0", C_IDLE);
    cyc();
    // Dependency through rt, and ignored when rt is not read.
    idle_in();
    idex_mem_read = 1'b1; idex_rt = 5'd5; ifid_rt = 5'd5; ifid_uses_rt = 1'b1;
    #1; chk_ctl("lu_rt", C_LU);
    cyc();
    ifid_uses_rt = 1'b0;
    #1; chk_ctl("lu_rt_unused", C_IDLE);
    chk_cnt("lu2", 2, 0, 0);
    cyc();

    // Single taken branch in RUN.
    idle_in();
    br_taken = 1'b1;
    #1; chk_ctl("br_run", C_FLUSH);
    cyc();
    br_taken = 1'b0;
    #1; chk_ctl("br_done", C_IDLE);
    chk_cnt("br1", 2, 0, 1);

    // Three-cycle memory hold.
    dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk_ctl($sformatf("hold3_c%0d", i), C_HOLD);
      cyc();
    end
    dmem_busy = 1'b0;
    #1; chk_ctl("hold3_exit", C_IDLE);
    chk_cnt("hold3", 2, 3, 1);

    // Branch arriving during a hold flushes on the first non-busy cycle.
    dmem_busy = 1'b1; br_taken = 1'b1;
    #1; chk_ctl("hbr_c0", C_HOLD);
    cyc();
    br_taken = 1'b0;
    #1; chk_ctl("hbr_c1", C_HOLD);
    cyc();
    dmem_busy = 1'b0;
    #1; chk_ctl("hbr_exit_flush", C_FLUSH);
    cyc();
    #1; chk_ctl("hbr_back_run", C_IDLE);
    chk_cnt("hbr", 2, 5, 2);

    // Branch beats load-use; hold beats load-use.
    set_lu(); br_taken = 1'b1;
    #1; chk_ctl("br_over_lu", C_FLUSH);
    cyc();
    br_taken = 1'b0; dmem_busy = 1'b1;
    #1; chk_ctl("hold_over_lu", C_HOLD);
    cyc();
    idle_in();
    #1; chk_cnt("prio", 2, 6, 3);

    // Pending flush exiting with br_taken also high counts once.
    dmem_busy = 1'b1; br_taken = 1'b1;
    cyc();
    dmem_busy = 1'b0;
    #1; chk_ctl("hbr_double_br", C_FLUSH);
    cyc();
    br_taken = 1'b0;
    #1; chk_ctl("hbr_double_done", C_IDLE);
    chk_cnt("hbr_double", 2, 7, 4);

    // Reset asserted in HOLD_BR drops the pending flush and clears counters asynchronously.
    dmem_busy = 1'b1; br_taken = 1'b1;
    cyc();
    br_taken = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_ctl("rst_mid_holdbr", C_RST);
    chk_cnt("rst_mid", 0, 0, 0);
    cyc();
    rst = 1'b0;
    dmem_busy = 1'b0;
    #1; chk_ctl("no_flush_after_rst", C_IDLE);
    cyc();
    #1; chk_cnt("after_rst", 0, 0, 0);

    // Saturation: five load-use events on the 2-bit instance.
    set_lu();
    for (int i = 0; i < 5; i++) cyc();
    idle_in();
    #1;
    chk("sat_lu_cnt2", {30'd0, s_lu_cnt}, 32'd3);
    chk("sat_lu_cnt16", {16'd0, lu_cnt}, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS pipeline. It drives the write-enable, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles three hazards:
- load-use data hazards, by inserting a single bubble;
- taken branches resolved in MEM, by squashing the three younger instructions;
- data-memory wait states, by freezing the whole pipeline.

It also keeps saturating performance counters for each event class.

## Interface
- CNT_W, 16, width of each saturating event counter
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ifid_rs  in  5  rs field of instruction in IF/ID
- ifid_rt  in  5  rt field of instruction in IF/ID
- ifid_uses_rs  in  1  ID instruction reads rs
- ifid_uses_rt  in  1  ID instruction reads rt
- idex_mem_read  in  1  MemRead bit of the M control group held in ID/EX
- idex_rt  in  5  RT field held in ID/EX (load destination)
- br_taken  in  1  branch in MEM resolved taken (PCSrc)
- dmem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_bubble  out  1  ID/EX loads zero WB/M/EX controls
- exmem_flush  out  1  EX/MEM loads zero WB/M controls
- pipe_hold  out  1  ID/EX and EX/MEM keep their contents
- memwb_bubble  out  1  MEM/WB loads zero WB controls
- lu_cnt  out  CNT_W  load-use bubbles inserted
- hold_cnt  out  CNT_W  cycles frozen by dmem_busy
- flush_cnt  out  CNT_W  branch flushes applied

## Operation
- FSM states: RUN, HOLD, HOLD_BR. HOLD_BR means a hold is active with a branch flush pending.
- Load-use detect: lu_det = idex_mem_read & (idex_rt != 0) & ((ifid_uses_rs & ifid_rs == idex_rt) | (ifid_uses_rt & ifid_rt == idex_rt)).
- Event priority, highest first: hold, then flush, then load-use.
- hold = dmem_busy.
- flush = ~dmem_busy & (br_taken | state == HOLD_BR).
- lu = ~dmem_busy & ~flush & lu_det.
- Output mapping, combinational from state and inputs (Mealy):
  - hold: pc_write=0, ifid_write=0, pipe_hold=1, memwb_bubble=1; all flush/bubble outputs 0.
  - flush: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1.
  - lu: pc_write=0, ifid_write=0, idex_bubble=1.
  - none: pc_write=1, ifid_write=1, all others 0.
- Transitions:
  - RUN → HOLD on dmem_busy & ~br_taken.
  - RUN → HOLD_BR on dmem_busy & br_taken.
  - HOLD → HOLD_BR on dmem_busy & br_taken.
  - HOLD → RUN on ~dmem_busy.
  - HOLD_BR → HOLD_BR while dmem_busy.
  - HOLD_BR → RUN on ~dmem_busy; the flush fires in that same cycle.
- A flush taken on HOLD_BR exit counts once, even if br_taken is also high in that cycle.
- Counters are registered. Each increments by 1 on the edge ending a cycle in which its event is active, and saturates at 2^CNT_W−1 with no wrap.

## Timing
- While rst=1, outputs are forced regardless of inputs:
  - pc_write=0, ifid_write=0, pipe_hold=0;
  - ifid_flush=1, idex_bubble=1, exmem_flush=1, memwb_bubble=1.
- On rst assertion: state=RUN and all counters=0 immediately (asynchronous).
- Reset asserted mid-hold or mid-pending drops the pending flush.
- Control outputs have zero latency: they are valid in the same cycle as their inputs and take effect at the next rising edge of the pipeline registers.
- Load-use costs exactly one bubble. On the following cycle the load has left ID/EX, so lu_det falls without needing extra state.
- A branch flush costs one cycle of control. PC loads the branch target on that same edge (PCSrc is external).
- A branch that arrives during a hold is never lost. It flushes on the first non-busy cycle.
- A multi-cycle dmem_busy holds for exactly as many cycles as busy is high. hold_cnt increments once per such cycle.

## Test plan
- Load then dependent: idex_mem_read=1, idex_rt=8, ifid_rs=8, ifid_uses_rs=1 → pc_write=0, ifid_write=0, idex_bubble=1 for one cycle; lu_cnt=1. With idex_rt=0 → no stall.
- br_taken=1 for one cycle in RUN → ifid_flush, idex_bubble, exmem_flush all 1 that cycle, pc_write=1; flush_cnt=1.
- dmem_busy=1 for 3 cycles → pipe_hold=1 and pc_write=0 for those 3 cycles; hold_cnt=3; state returns to RUN.
- dmem_busy=1 for 2 cycles with br_taken=1 in the first, then dmem_busy=0 and br_taken=0 → flush asserted on the first non-busy cycle; flush_cnt=1; state RUN.
- br_taken and lu_det both true → only the flush pattern appears; lu_cnt unchanged. dmem_busy together with lu_det → hold only.
- Counter saturation with CNT_W=2: 5 load-use events → lu_cnt=3.
- Assert rst during HOLD_BR → state RUN, counters 0, and no flush after release.
